apes_rocket_rdout: RTL and testbench

- Readout responder for the APES acquisition sequencer.
- When `en_rocket_rd` is held high, reads the accumulated count bins from the counter bin store and frames them into 16-bit telemetry words.
- Streams the words to the rocket telemetry interface over a valid/ready handshake, then pulses `rdout_done` back to the sequencer.
- Sits between the sequencer, the count bin store, and the rocket TM serializer.

---
 rtl/apes_rocket_rdout_if.sv | 39 +++
 rtl/apes_rocket_rdout.sv | 229 ++++++++++++++++++++++
 tb/tb_apes_rocket_rdout.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/apes_rocket_rdout_if.sv
// ---------------------------------------------------------------------------
// apes_rocket_rdout_if
// Bundles the two buses of the rocket readout responder:
//   - bin store read port: bin_rd / bin_addr out, bin_data back one cycle later
//   - telemetry word stream: tm_data / tm_valid out, tm_ready back
// Telemetry handshake: a word moves on every clock edge where
// tm_valid && tm_ready; once tm_valid is high, tm_data is frozen and
// tm_valid stays high until that transfer happens.
// ---------------------------------------------------------------------------
interface apes_rocket_rdout_if #(
    parameter int ADDR_W = 4
);
    logic              bin_rd;
    logic [ADDR_W-1:0] bin_addr;
    logic [15:0]       bin_data;
    logic [15:0]       tm_data;
    logic              tm_valid;
    logic              tm_ready;

    // Readout responder side
    modport master (
        output bin_rd,
        output bin_addr,
        input  bin_data,
        output tm_data,
        output tm_valid,
        input  tm_ready
    );

    // Bin store / TM serializer side
    modport slave (
        input  bin_rd,
        input  bin_addr,
        output bin_data,
        input  tm_data,
        input  tm_valid,
        output tm_ready
    );
endinterface

// File: rtl/apes_rocket_rdout.sv
// ---------------------------------------------------------------------------
// apes_rocket_rdout
// Readout responder for the APES acquisition sequencer. On a held
// en_rocket_rd request it reads NBINS count bins from the bin store and
// streams a telemetry frame:
//   SYNC_WORD, frame_cnt, bin[0] .. bin[NBINS-1] [, checksum]
// then pulses rdout_done for one cycle and waits for the request to drop.
//
// Optional feature macro: APES_RD_CHKSUM_EN
//   defined   -> trailing 16-bit checksum word (frame_cnt + all bins, mod 2^16)
//   undefined -> no checksum accumulator, no CHK state, NBINS+2 words/frame
//
// Each bin costs three cycles: the DATA transfer cycle, the BINRD cycle in
// which the read strobe is presented to the synchronous store, and the FETCH
// cycle in which the returned data is captured.
// state_dbg exposes the current FSM state for observation.
// ---------------------------------------------------------------------------
module apes_rocket_rdout #(
    parameter int          NBINS     = 16,
    parameter int          ADDR_W    = 4,
    parameter logic [15:0] SYNC_WORD = 16'hEB90
) (
    input  logic                 clk50,
    input  logic                 rst_n,
    input  logic                 en_rocket_rd,
    output logic                 rdout_done,
    output logic [15:0]          frame_cnt,
    output logic [3:0]           state_dbg,
    apes_rocket_rdout_if.master  bus
);

    // Address of the final bin in a frame
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NBINS - 1);

    typedef enum logic [3:0] {
        IDLE  = 4'd0,
        SYNC  = 4'd1,
        FCNT  = 4'd2,
        BINRD = 4'd3,
        FETCH = 4'd4,
        DATA  = 4'd5,
`ifdef APES_RD_CHKSUM_EN
        CHK   = 4'd6,
`endif
        DONE  = 4'd7,
        HOLD  = 4'd8
    } state_t;

    state_t state_q, state_d;

    // Registered outputs and their next values
    logic [15:0]       tm_data_q, tm_data_d;
    logic              tm_valid_q, tm_valid_d;
    logic              bin_rd_q, bin_rd_d;
    logic [ADDR_W-1:0] bin_addr_q, bin_addr_d;
    logic              done_q, done_d;

`ifdef APES_RD_CHKSUM_EN
    logic [15:0]       chk_q, chk_d;
`endif

    // A telemetry word is accepted this cycle
    logic xfer;
    assign xfer = tm_valid_q && bus.tm_ready;

    // State register
    always_ff @(posedge clk50 or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and next-output decode; every register holds unless told otherwise
    always_comb begin
        state_d    = state_q;
        tm_data_d  = tm_data_q;
        tm_valid_d = tm_valid_q;
        bin_rd_d   = 1'b0;
        bin_addr_d = bin_addr_q;
        done_d     = 1'b0;
`ifdef APES_RD_CHKSUM_EN
        chk_d      = chk_q;
`endif

        unique case (state_q)
            IDLE: begin
                if (en_rocket_rd) begin
                    tm_data_d  = SYNC_WORD;
                    tm_valid_d = 1'b1;
`ifdef APES_RD_CHKSUM_EN
                    chk_d      = 16'h0000;
`endif
                    state_d    = SYNC;
                end
            end

            SYNC: begin
                // Sync word accepted: present the frame counter next
                if (xfer) begin
                    tm_data_d = frame_cnt;
`ifdef APES_RD_CHKSUM_EN
                    chk_d     = chk_q + frame_cnt;
`endif
                    state_d   = FCNT;
                end
            end

            FCNT: begin
                // Counter word accepted: start reading bin 0
                if (xfer) begin
                    tm_valid_d = 1'b0;
                    bin_rd_d   = 1'b1;
                    bin_addr_d = '0;
                    state_d    = BINRD;
                end
            end

            BINRD: begin
                // Store samples the strobe on this edge; data returns next cycle
                state_d = FETCH;
            end

            FETCH: begin
                tm_data_d  = bus.bin_data;
                tm_valid_d = 1'b1;
`ifdef APES_RD_CHKSUM_EN
                chk_d      = chk_q + bus.bin_data;
`endif
                state_d    = DATA;
            end

            DATA: begin
                if (xfer) begin
                    if (bin_addr_q != LAST_ADDR) begin
                        bin_addr_d = bin_addr_q + 1'b1;
                        bin_rd_d   = 1'b1;
                        tm_valid_d = 1'b0;
                        state_d    = BINRD;
                    end else begin
`ifdef APES_RD_CHKSUM_EN
                        // chk_q already includes the last bin, added in FETCH
                        tm_data_d  = chk_q;
                        state_d    = CHK;
`else
                        tm_valid_d = 1'b0;
                        state_d    = DONE;
`endif
                    end
                end
            end

`ifdef APES_RD_CHKSUM_EN
            CHK: begin
                if (xfer) begin
                    tm_valid_d = 1'b0;
                    state_d    = DONE;
                end
            end
`endif

            DONE: begin
                tm_valid_d = 1'b0;
                done_d     = 1'b1;
                bin_addr_d = '0;
                state_d    = HOLD;
            end

            HOLD: begin
                // Request must drop before another frame may start
                if (!en_rocket_rd) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d    = IDLE;
                tm_valid_d = 1'b0;
                bin_addr_d = '0;
            end
        endcase
    end

    // Output and datapath registers
    always_ff @(posedge clk50 or negedge rst_n) begin
        if (!rst_n) begin
            tm_data_q  <= 16'h0000;
            tm_valid_q <= 1'b0;
            bin_rd_q   <= 1'b0;
            bin_addr_q <= '0;
            done_q     <= 1'b0;
        end else begin
            tm_data_q  <= tm_data_d;
            tm_valid_q <= tm_valid_d;
            bin_rd_q   <= bin_rd_d;
            bin_addr_q <= bin_addr_d;
            done_q     <= done_d;
        end
    end

`ifdef APES_RD_CHKSUM_EN
    // Running checksum of frame_cnt and bin words
    always_ff @(posedge clk50 or negedge rst_n) begin
        if (!rst_n) begin
            chk_q <= 16'h0000;
        end else begin
            chk_q <= chk_d;
        end
    end
`endif

    // Completed-frame counter, advanced once per frame and wrapping at 16 bits
    always_ff @(posedge clk50 or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt <= 16'h0000;
        end else if (state_q == DONE) begin
            frame_cnt <= frame_cnt + 16'h0001;
        end
    end

    assign bus.tm_data  = tm_data_q;
    assign bus.tm_valid = tm_valid_q;
    assign bus.bin_rd   = bin_rd_q;
    assign bus.bin_addr = bin_addr_q;
    assign rdout_done   = done_q;
    assign state_dbg    = state_q;

endmodule

// File: tb/tb_apes_rocket_rdout.sv
// ---------------------------------------------------------------------------
// tb_apes_rocket_rdout
// Frame scoreboard for apes_rocket_rdout. Build with +define+APES_RD_CHKSUM_EN
// to exercise the checksum build; the reference model follows the same macro.
// ---------------------------------------------------------------------------
module tb_apes_rocket_rdout;

    localparam int          NBINS  = 16;
    localparam int          ADDR_W = 4;
    localparam logic [15:0] SYNC   = 16'hEB90;
`ifdef APES_RD_CHKSUM_EN
    localparam int FRAME_WORDS = NBINS + 3;
    localparam int FRAME_CYC   = 2 + 3 * NBINS + 1 + 1;
`else
    localparam int FRAME_WORDS = NBINS + 2;
    localparam int FRAME_CYC   = 2 + 3 * NBINS + 1;
`endif

    // ---------------- clock / reset ----------------
    logic        clk50 = 1'b0;
    logic        rst_n = 1'b0;
    logic        en_rocket_rd = 1'b0;
    logic        rdout_done;
    logic [15:0] frame_cnt;
    logic [3:0]  state_dbg;

    always #10 clk50 = ~clk50;

    apes_rocket_rdout_if #(.ADDR_W(ADDR_W)) bus ();

    apes_rocket_rdout #(
        .NBINS    (NBINS),
        .ADDR_W   (ADDR_W),
        .SYNC_WORD(SYNC)
    ) dut (
        .clk50       (clk50),
        .rst_n       (rst_n),
        .en_rocket_rd(en_rocket_rd),
        .rdout_done  (rdout_done),
        .frame_cnt   (frame_cnt),
        .state_dbg   (state_dbg),
        .bus         (bus)
    );

    // ---------------- scoreboard state ----------------
    logic [15:0] exp_q[$];
    logic [15:0] fc_q[$];
    logic [15:0] mem [NBINS];
    logic [15:0] fc_model = 16'h0000;
    int total = 0;
    int bad   = 0;

    int rdy_mode   = 0;   // 0: always ready, 1: random, 2: stall on word 5
    int stall_left = 0;
    int xfer_idx   = 0;
    int rd_cnt     = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- bin store model (synchronous read) ----------------
    initial bus.bin_data = 16'h0000;
    always @(posedge clk50) begin
        if (bus.bin_rd) bus.bin_data <= mem[bus.bin_addr];
    end

    // ---------------- tm_ready driver ----------------
    initial bus.tm_ready = 1'b1;
    always @(posedge clk50) begin
        #1;
        case (rdy_mode)
            1: bus.tm_ready = ($urandom_range(0, 3) != 0);
            2: begin
                if (bus.tm_valid && xfer_idx == 5 && stall_left > 0) begin
                    bus.tm_ready = 1'b0;
                    stall_left--;
                end else begin
                    bus.tm_ready = 1'b1;
                end
            end
            default: bus.tm_ready = 1'b1;
        endcase
    end

    // ---------------- reference model ----------------
    // A frame is the sync word, the current count, every bin and optionally
    // the 16-bit sum of count and bins.
    task automatic push_frame();
        logic [15:0] sum;
        sum = fc_model;
        exp_q.push_back(SYNC);
        exp_q.push_back(fc_model);
        for (int i = 0; i < NBINS; i++) begin
            exp_q.push_back(mem[i]);
            sum = sum + mem[i];
        end
`ifdef APES_RD_CHKSUM_EN
        exp_q.push_back(sum);
`endif
        fc_model = fc_model + 16'h0001;
        fc_q.push_back(fc_model);
    endtask

    // ---------------- monitor ----------------
    logic        held = 1'b0;
    logic [15:0] held_data = 16'h0000;
    always @(negedge clk50) begin
        if (!rst_n) begin
            held     = 1'b0;
            xfer_idx = 0;
            rd_cnt   = 0;
        end else begin
            if (held) begin
                check("stall_valid", {31'b0, bus.tm_valid}, 32'd1);
                check("stall_data", {16'b0, bus.tm_data}, {16'b0, held_data});
            end
            if (bus.bin_rd) begin
                rd_cnt++;
                check("bin_rd_vs_valid", {31'b0, bus.tm_valid}, 32'd0);
                check("bin_addr_range", {31'b0, (bus.bin_addr <= ADDR_W'(NBINS - 1))}, 32'd1);
            end
            if (bus.tm_valid && bus.tm_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_word", {16'b0, bus.tm_data}, 32'hFFFF_FFFF);
                end else begin
                    check("tm_word", {16'b0, bus.tm_data}, {16'b0, exp_q.pop_front()});
                end
                xfer_idx++;
                held = 1'b0;
            end else if (bus.tm_valid) begin
                held      = 1'b1;
                held_data = bus.tm_data;
            end else begin
                held = 1'b0;
            end
            if (rdout_done) begin
                check("frame_words", xfer_idx, FRAME_WORDS);
                check("frame_bin_reads", rd_cnt, NBINS);
                check("exp_q_drained", exp_q.size(), 0);
                if (fc_q.size() == 0) begin
                    check("unexpected_done", 32'd1, 32'd0);
                end else begin
                    check("frame_cnt_after", {16'b0, frame_cnt}, {16'b0, fc_q.pop_front()});
                end
                xfer_idx = 0;
                rd_cnt   = 0;
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Wait (bounded) for rdout_done; returns the number of negedges waited.
    task automatic wait_done(output int n);
        n = 0;
        while (!rdout_done && n < 3000) begin
            @(negedge clk50);
            n++;
        end
        if (!rdout_done) begin
            check("done_timeout", 32'd0, 32'd1);
            exp_q.delete();
            fc_q.delete();
        end
    endtask

    // After rdout_done keep the request up for 'late' cycles, then drop it;
    // no new word may appear meanwhile.
    task automatic finish_frame(input int late);
        for (int i = 0; i < late; i++) begin
            @(negedge clk50);
            check("late_req_no_frame", {31'b0, bus.tm_valid}, 32'd0);
        end
        en_rocket_rd = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk50);
            check("idle_no_valid", {31'b0, bus.tm_valid}, 32'd0);
        end
    endtask

    task automatic fill_random();
        for (int i = 0; i < NBINS; i++) mem[i] = 16'($urandom_range(0, 16'hFFFF));
    endtask

    task automatic run_frame(input int mode, input bit drop_early);
        int n;
        rdy_mode = mode;
        stall_left = 5;
        push_frame();
        @(negedge clk50);
        en_rocket_rd = 1'b1;
        if (drop_early) begin
            n = 0;
            while (xfer_idx < 3 && n < 500) begin
                @(negedge clk50);
                n++;
            end
            en_rocket_rd = 1'b0;
        end
        wait_done(n);
        finish_frame(drop_early ? 0 : 1);
        rdy_mode = 0;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int n;
        for (int i = 0; i < NBINS; i++) mem[i] = 16'(i + 1);

        // Reset with the request already high
        rst_n = 1'b0;
        en_rocket_rd = 1'b1;
        repeat (3) @(negedge clk50);
        check("rst_done", {31'b0, rdout_done}, 32'd0);
        check("rst_bin_rd", {31'b0, bus.bin_rd}, 32'd0);
        check("rst_bin_addr", {28'b0, bus.bin_addr}, 32'd0);
        check("rst_tm_data", {16'b0, bus.tm_data}, 32'd0);
        check("rst_tm_valid", {31'b0, bus.tm_valid}, 32'd0);
        check("rst_frame_cnt", {16'b0, frame_cnt}, 32'd0);

        // First frame: bins 1..16, ready tied high
        push_frame();
        #2 rst_n = 1'b1;
        @(negedge clk50);
        check("first_valid", {31'b0, bus.tm_valid}, 32'd1);
        check("first_sync", {16'b0, bus.tm_data}, {16'b0, SYNC});
        wait_done(n);
        check("frame_latency", n, FRAME_CYC);
        @(negedge clk50);
        check("done_one_cycle", {31'b0, rdout_done}, 32'd0);
        check("frame_cnt_1", {16'b0, frame_cnt}, 32'd1);
        finish_frame(2);

        // Same bins under a 5-cycle stall on bin[3]
        run_frame(2, 1'b0);

        // Random bins, random backpressure, one with an early request drop
        for (int f = 0; f < 4; f++) begin
            fill_random();
            run_frame(1, f == 2);
        end

        // Abort during bin[7]
        for (int i = 0; i < NBINS; i++) mem[i] = 16'hA000 + 16'(i);
        push_frame();
        @(negedge clk50);
        en_rocket_rd = 1'b1;
        n = 0;
        while (!(bus.tm_valid && bus.tm_data == 16'hA007) && n < 500) begin
            @(negedge clk50);
            n++;
        end
        check("abort_reached_bin7", {16'b0, bus.tm_data}, 32'h0000_A007);
        #3 rst_n = 1'b0;
        #1;
        check("abort_tm_valid", {31'b0, bus.tm_valid}, 32'd0);
        check("abort_frame_cnt", {16'b0, frame_cnt}, 32'd0);
        exp_q.delete();
        fc_q.delete();
        fc_model = 16'h0000;
        push_frame();
        @(negedge clk50);
        #2 rst_n = 1'b1;
        @(negedge clk50);
        check("restart_sync", {16'b0, bus.tm_data}, {16'b0, SYNC});
        wait_done(n);
        finish_frame(1);

        // Wrap of the frame counter
        @(posedge clk50);
        force dut.frame_cnt = 16'hFFFF;
        @(posedge clk50);
        #1 release dut.frame_cnt;
        fc_model = 16'hFFFF;
        fill_random();
        run_frame(1, 1'b0);
        check("wrap_frame_cnt", {16'b0, frame_cnt}, 32'd0);

        repeat (5) @(negedge clk50);
        check("final_exp_q_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global time bound
    initial begin
        #4000000;
        bad++;
        $display("FAIL watchdog: simulation did not complete in time");
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
